// File: rtl/tetris_input_conditioner.sv
// Per-button 2-flop synchroniser, counter debouncer, press pulse and optional
// Tetris-style delayed auto-repeat. Optional feature macro: AUTOREPEAT_EN.
//
//   state  | meaning
//   IDLE   | released, or channel without auto-repeat
//   HELD   | initial press pulsed, counting REPEAT_DELAY to first repeat
//   REPEAT | auto-repeating, one pulse every REPEAT_RATE cycles
module tetris_input_conditioner #(
  parameter int                 NUM_BTN         = 4,
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter int                 REPEAT_DELAY    = 4000000,
  parameter int                 REPEAT_RATE     = 1250000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b1101,
  parameter int                 CNT_W           = 23
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic               any_press_o
);

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_TC  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } rstate_t;
`endif

  // Zero-cycle counts would break the one-pulse-per-cycle guarantee.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      $bits(REPEAT_MASK) != NUM_BTN) begin : g_bad_params
  end

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;
  logic [NUM_BTN-1:0] stable_v;
  logic [NUM_BTN-1:0] press_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw_i;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             accept;
    logic             rise;
    logic             rep_pulse;
    logic             press_q;

    assign accept = (s2[i] != stable) && (cnt == DEB_TC);
    assign rise   = accept & s2[i];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (s2[i] == stable) begin
        cnt <= '0;
      end else if (cnt == DEB_TC) begin
        stable <= s2[i];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

`ifdef AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      logic             fall;
      rstate_t          state;
      rstate_t          state_nxt;
      logic [CNT_W-1:0] rcnt;
      logic [CNT_W-1:0] rcnt_nxt;

      assign fall = accept & ~s2[i];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state <= IDLE;
          rcnt  <= '0;
        end else begin
          state <= state_nxt;
          rcnt  <= rcnt_nxt;
        end
      end

      always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt + CNT_W'(1);
        if (fall) begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else begin
          case (state)
            IDLE: begin
              rcnt_nxt = '0;
              if (rise) state_nxt = HELD;
            end
            HELD: begin
              if (rcnt == DELAY_TC) begin
                rcnt_nxt  = '0;
                state_nxt = REPEAT;
              end
            end
            REPEAT: begin
              if (rcnt == RATE_TC) rcnt_nxt = '0;
            end
            default: begin
              state_nxt = IDLE;
              rcnt_nxt  = '0;
            end
          endcase
        end
      end

      // A release landing on a terminal count suppresses that repeat.
      always_comb begin
        rep_pulse = 1'b0;
        if (!fall) begin
          case (state)
            HELD:    rep_pulse = (rcnt == DELAY_TC);
            REPEAT:  rep_pulse = (rcnt == RATE_TC);
            default: rep_pulse = 1'b0;
          endcase
        end
      end
    end else begin : g_norep
      assign rep_pulse = 1'b0;
    end
`else
    assign rep_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) press_q <= 1'b0;
      else          press_q <= rise | rep_pulse;
    end

    assign stable_v[i] = stable;
    assign press_v[i]  = press_q;
  end

  assign btn_level_o = stable_v;
  assign btn_press_o = press_v;
  assign any_press_o = |press_v;

endmodule
